pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, jump-address width.
REQ-002 Parameter N_SRC, default 3, number of hold-request sources; index 0 has highest priority.
REQ-003 Parameter FLUSH_LEN, default 2, bubble cycles issued per taken jump (legal range 1..8).
REQ-004 Parameter TIMEOUT, default 1024, continuous-hold cycles before the watchdog fires (legal range 2..65535).
REQ-005 Parameter CNT_W, default 32, width of the performance counters.
REQ-006 The block has one clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 jump_addr_i  input  ADDR_W  branch/jump target from ex.
REQ-010 jump_ena_i  input  1  jump request from ex.
REQ-011 hold_req_i  input  N_SRC  per-source hold requests (ex, bus, debug by default).
REQ-012 wdt_clr_i  input  1  clears the sticky watchdog flag.
REQ-013 jump_addr_o  output  ADDR_W  target to pc/if_id.
REQ-014 jump_ena_o  output  1  jump commit strobe to pc/if_id/id_ex.
REQ-015 hold_flag_o  output  1  stall to if_id/id_ex.
REQ-016 flush_o  output  1  bubble insertion to if_id/id_ex.
REQ-017 hold_src_o  output  max(1,clog2(N_SRC))  index of the highest-priority active hold source; 0 when none.
REQ-018 hold_timeout_o  output  1  sticky watchdog flag.
REQ-019 stall_cnt_o  output  CNT_W  cycles with hold_flag_o=1.
REQ-020 jump_cnt_o  output  CNT_W  committed jumps.

Function
REQ-021 The block has three states: RUN, JPEND (jump captured, waiting for holds to clear) and FLUSH (bubbles in progress).
REQ-022 hold_any = OR of hold_req_i.
REQ-023 In RUN with jump_ena_i=1 and hold_any=0: jump_ena_o=1 and jump_addr_o=jump_addr_i in the same cycle (zero latency); flush_o=1; next state FLUSH with bubble counter = FLUSH_LEN-1, or RUN if FLUSH_LEN=1.
REQ-024 In RUN with jump_ena_i=1 and hold_any=1: jump_ena_o=0; jump_addr_i is latched into jump_addr_q; next state JPEND.
REQ-025 In JPEND: jump_ena_i and jump_addr_i are ignored (first capture wins); jump_ena_o=0 while hold_any=1.
REQ-026 In JPEND, in the first cycle with hold_any=0: jump_ena_o=1, jump_addr_o=jump_addr_q, flush_o=1, and the next state follows the REQ-023 rule.
REQ-027 In FLUSH: flush_o=1 and the counter decrements each cycle; the block returns to RUN in the cycle after the counter reads 1.
REQ-028 In FLUSH, a jump_ena_i is handled as in RUN (REQ-023/REQ-024), which restarts or pends; the newer jump overrides the flush.
REQ-029 When no jump is being committed, jump_addr_o = jump_addr_i.
REQ-030 hold_flag_o = hold_any OR jump_ena_o OR flush_o OR (state==JPEND).
REQ-031 hold_src_o is combinational: it is the lowest set index of hold_req_i.
REQ-032 Watchdog: the hold-run counter increments while hold_any=1 and clears when hold_any=0; it saturates at TIMEOUT.
REQ-033 hold_timeout_o sets in the cycle after the hold-run counter reaches TIMEOUT and stays set until wdt_clr_i=1; wdt_clr_i wins over a simultaneous set.
REQ-034 stall_cnt_o increments in each cycle that hold_flag_o=1.
REQ-035 jump_cnt_o increments in each cycle that jump_ena_o=1.
REQ-036 Both performance counters wrap modulo 2^CNT_W.

Reset
REQ-037 While rst=1: state=RUN, all counters 0, jump_addr_q=0, hold_timeout_o=0.
REQ-038 While rst=1: jump_ena_o, flush_o and hold_flag_o are forced to 0, and jump_addr_o=0, regardless of inputs.
REQ-039 Reset asserted mid-JPEND or mid-FLUSH discards the pending jump and the remaining bubbles.
REQ-040 The first cycle after reset release behaves as RUN.

Verification
REQ-041 Scenario: jump_ena_i=1, jump_addr_i=0x100, no holds -> same cycle jump_ena_o=1, jump_addr_o=0x100; flush_o=1 for 2 cycles (FLUSH_LEN=2); jump_cnt_o=1.
REQ-042 Scenario: hold_req_i=3'b010 for 5 cycles with jump 0x200 in its first cycle -> jump_ena_o=0 for 5 cycles, hold_src_o=1; on cycle 6 jump_ena_o=1, jump_addr_o=0x200; a second jump 0x300 during JPEND is ignored.
REQ-043 Scenario: TIMEOUT=4, hold_req_i=3'b100 held for 6 cycles -> hold_timeout_o rises after the 4th hold cycle, stays high after hold drops, clears the cycle after wdt_clr_i=1.
REQ-044 Scenario: jump 0x40, then a new jump 0x80 in the first FLUSH cycle -> jump_ena_o pulses twice, the flush restarts, and jump_cnt_o=2.
REQ-045 Scenario: rst pulsed during JPEND -> all outputs 0, the captured jump is never committed, and stall_cnt_o=0.
REQ-046 Scenario: stall_cnt_o preloaded to all-ones through hold cycles at CNT_W=4 -> the 16th stall cycle wraps it to 0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline control bundle between ex/bus/debug requesters and pipe_ctrl
//
// Purpose: groups the jump, hold, watchdog and counter signals of pipe_ctrl.
// Signal names keep the _i/_o suffix as seen from pipe_ctrl.
//   jump_addr_i    [ADDR_W] branch/jump target from ex
//   jump_ena_i     [1]      jump request from ex
//   hold_req_i     [N_SRC]  per-source hold requests, index 0 highest priority
//   wdt_clr_i      [1]      clears the sticky watchdog flag
//   jump_addr_o    [ADDR_W] target to pc/if_id
//   jump_ena_o     [1]      jump commit strobe
//   hold_flag_o    [1]      stall to if_id/id_ex
//   flush_o        [1]      bubble insertion to if_id/id_ex
//   hold_src_o     [SRC_W]  highest-priority active hold source
//   hold_timeout_o [1]      sticky watchdog flag
//   stall_cnt_o    [CNT_W]  stalled-cycle counter
//   jump_cnt_o     [CNT_W]  committed-jump counter
// Modports: slave = pipe_ctrl, master = the pipeline side.

interface pipe_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int N_SRC  = 3,
    parameter int CNT_W  = 32
) ();
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [ADDR_W-1:0] jump_addr_i;
    logic              jump_ena_i;
    logic [N_SRC-1:0]  hold_req_i;
    logic              wdt_clr_i;

    logic [ADDR_W-1:0] jump_addr_o;
    logic              jump_ena_o;
    logic              hold_flag_o;
    logic              flush_o;
    logic [SRC_W-1:0]  hold_src_o;
    logic              hold_timeout_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  jump_cnt_o;

    modport slave (
        input  jump_addr_i,
        input  jump_ena_i,
        input  hold_req_i,
        input  wdt_clr_i,
        output jump_addr_o,
        output jump_ena_o,
        output hold_flag_o,
        output flush_o,
        output hold_src_o,
        output hold_timeout_o,
        output stall_cnt_o,
        output jump_cnt_o
    );

    modport master (
        output jump_addr_i,
        output jump_ena_i,
        output hold_req_i,
        output wdt_clr_i,
        input  jump_addr_o,
        input  jump_ena_o,
        input  hold_flag_o,
        input  flush_o,
        input  hold_src_o,
        input  hold_timeout_o,
        input  stall_cnt_o,
        input  jump_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline jump/hold/flush controller with hold watchdog and perf counters
//
// Purpose: commits jumps from ex with zero latency when no hold is active,
// parks a jump while holds are active (first capture wins), inserts FLUSH_LEN
// bubbles per committed jump, reports the highest-priority hold source,
// flags holds that last TIMEOUT cycles, and counts stalls and jumps.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   ctrl pipe_ctrl_if.slave bundle (see rtl/pipe_ctrl_if.sv)
// Parameters: ADDR_W, N_SRC, FLUSH_LEN (1..8), TIMEOUT (2..65535), CNT_W.

module pipe_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int N_SRC     = 3,
    parameter int FLUSH_LEN = 2,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   ctrl
);
    localparam int          SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [3:0]  BUB_LD = 4'(FLUSH_LEN - 1);
    localparam logic [15:0] TMO    = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_JPEND = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_bub_cnt;
    logic [ADDR_W-1:0] r_jump_addr_q;
    logic [15:0]       r_hold_run;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_jump_cnt;

    logic              w_hold_any;
    logic              w_commit_new;
    logic              w_commit_pend;
    logic              w_commit;
    logic              w_flush;
    logic              w_hold_flag;
    logic              w_wdt_hit;
    logic [ADDR_W-1:0] w_jump_addr;
    logic [SRC_W-1:0]  w_hold_src;

    assign w_hold_any = |ctrl.hold_req_i;

    // A fresh jump is accepted in RUN and FLUSH; JPEND ignores new requests.
    assign w_commit_new  = (r_state != ST_JPEND) && ctrl.jump_ena_i && !w_hold_any;
    assign w_commit_pend = (r_state == ST_JPEND) && !w_hold_any;

    // Outputs are combinational so a jump commits in the cycle it arrives;
    // reset forces them low regardless of inputs.
    assign w_commit    = !rst && (w_commit_new || w_commit_pend);
    assign w_flush     = !rst && (w_commit || (r_state == ST_FLUSH));
    assign w_hold_flag = !rst && (w_hold_any || w_commit || w_flush || (r_state == ST_JPEND));
    assign w_jump_addr = rst           ? '0 :
                         w_commit_pend ? r_jump_addr_q : ctrl.jump_addr_i;

    // Lowest set index wins; scanning downward leaves the lowest one last.
    always_comb begin
        w_hold_src = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (ctrl.hold_req_i[i]) begin
                w_hold_src = SRC_W'(i);
            end
        end
    end

    // Flag rises together with the run counter reaching TIMEOUT.
    assign w_wdt_hit = w_hold_any && (r_hold_run >= (TMO - 16'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_bub_cnt     <= '0;
            r_jump_addr_q <= '0;
        end else begin
            case (r_state)
                ST_RUN, ST_FLUSH: begin
                    if (ctrl.jump_ena_i) begin
                        // A newer jump overrides any bubbles still in flight.
                        if (w_hold_any) begin
                            r_jump_addr_q <= ctrl.jump_addr_i;
                            r_state       <= ST_JPEND;
                        end else if (FLUSH_LEN == 1) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_state   <= ST_FLUSH;
                            r_bub_cnt <= BUB_LD;
                        end
                    end else if (r_state == ST_FLUSH) begin
                        if (r_bub_cnt <= 4'd1) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_bub_cnt <= r_bub_cnt - 4'd1;
                        end
                    end
                end
                ST_JPEND: begin
                    if (!w_hold_any) begin
                        if (FLUSH_LEN == 1) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_state   <= ST_FLUSH;
                            r_bub_cnt <= BUB_LD;
                        end
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_run <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (!w_hold_any) begin
                r_hold_run <= '0;
            end else if (r_hold_run < TMO) begin
                r_hold_run <= r_hold_run + 16'd1;
            end
            // Clear has priority over a simultaneous set.
            if (ctrl.wdt_clr_i) begin
                r_timeout <= 1'b0;
            end else if (w_wdt_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_jump_cnt  <= '0;
        end else begin
            if (w_hold_flag) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_commit) begin
                r_jump_cnt <= r_jump_cnt + CNT_W'(1);
            end
        end
    end

    assign ctrl.jump_addr_o    = w_jump_addr;
    assign ctrl.jump_ena_o     = w_commit;
    assign ctrl.hold_flag_o    = w_hold_flag;
    assign ctrl.flush_o        = w_flush;
    assign ctrl.hold_src_o     = w_hold_src;
    assign ctrl.hold_timeout_o = r_timeout;
    assign ctrl.stall_cnt_o    = r_stall_cnt;
    assign ctrl.jump_cnt_o     = r_jump_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl

module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.ADDR_W(32), .N_SRC(3), .CNT_W(4)) bus ();

    pipe_ctrl #(
        .ADDR_W    (32),
        .N_SRC     (3),
        .FLUSH_LEN (2),
        .TIMEOUT   (4),
        .CNT_W     (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    typedef struct {
        logic        rst;
        logic        jena;
        logic [31:0] addr;
        logic        flush;
        logic        hold;
        logic [1:0]  src;
        logic        tmo;
    } exp_t;

    exp_t       sb[$];
    int         n_test = 0;
    int         n_fail = 0;
    int         step_no = 0;
    logic [3:0] exp_stall = 4'd0;
    logic [3:0] exp_jcnt  = 4'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_test++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s@%0d observed=%0h expected=%0h", tag, step_no, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        if (e.rst) begin
            exp_stall = 4'd0;
            exp_jcnt  = 4'd0;
        end
        chk("jump_ena",  32'(bus.jump_ena_o),     32'(e.jena));
        chk("jump_addr", bus.jump_addr_o,         e.addr);
        chk("flush",     32'(bus.flush_o),        32'(e.flush));
        chk("hold_flag", 32'(bus.hold_flag_o),    32'(e.hold));
        chk("hold_src",  32'(bus.hold_src_o),     32'(e.src));
        chk("timeout",   32'(bus.hold_timeout_o), 32'(e.tmo));
        chk("stall_cnt", 32'(bus.stall_cnt_o),    32'(exp_stall));
        chk("jump_cnt",  32'(bus.jump_cnt_o),     32'(exp_jcnt));
        if (!e.rst) begin
            exp_stall = exp_stall + 4'(e.hold);
            exp_jcnt  = exp_jcnt + 4'(e.jena);
        end
    endtask

    // One clock cycle: drive inputs after the edge, queue the expectation,
    // then compare mid-cycle.
    task automatic step(input logic r, input logic je, input logic [31:0] ja,
                        input logic [2:0] hr, input logic clr,
                        input logic e_je, input logic [31:0] e_a, input logic e_fl,
                        input logic e_hd, input logic [1:0] e_src, input logic e_to);
        exp_t e;
        @(posedge clk);
        #1;
        step_no++;
        rst             = r;
        bus.jump_ena_i  = je;
        bus.jump_addr_i = ja;
        bus.hold_req_i  = hr;
        bus.wdt_clr_i   = clr;
        e.rst   = r;
        e.jena  = e_je;
        e.addr  = e_a;
        e.flush = e_fl;
        e.hold  = e_hd;
        e.src   = e_src;
        e.tmo   = e_to;
        sb.push_back(e);
        #3;
        check_out();
    endtask

    initial begin
        bus.jump_ena_i  = 1'b0;
        bus.jump_addr_i = '0;
        bus.hold_req_i  = '0;
        bus.wdt_clr_i   = 1'b0;

        // Reset forces outputs low even with a jump and a hold requested
        step(1, 1, 32'h55, 3'b001, 0,  0, 32'h0,   0, 0, 0, 0);
        step(1, 1, 32'h55, 3'b001, 0,  0, 32'h0,   0, 0, 0, 0);
        step(0, 0, 32'h11, 3'b000, 0,  0, 32'h11,  0, 0, 0, 0);

        // Zero-latency jump, two bubble cycles
        step(0, 1, 32'h100, 3'b000, 0, 1, 32'h100, 1, 1, 0, 0);
        step(0, 0, 32'hAA,  3'b000, 0, 0, 32'hAA,  1, 1, 0, 0);
        step(0, 0, 32'hAB,  3'b000, 0, 0, 32'hAB,  0, 0, 0, 0);

        // Jump under a 5-cycle hold from source 1; second jump ignored
        step(0, 1, 32'h200, 3'b010, 0, 0, 32'h200, 0, 1, 1, 0);
        step(0, 1, 32'h300, 3'b010, 0, 0, 32'h300, 0, 1, 1, 0);
        step(0, 0, 32'h0,   3'b010, 0, 0, 32'h0,   0, 1, 1, 0);
        step(0, 0, 32'h0,   3'b010, 0, 0, 32'h0,   0, 1, 1, 0);
        step(0, 0, 32'h0,   3'b010, 0, 0, 32'h0,   0, 1, 1, 1);
        step(0, 0, 32'h0,   3'b000, 0, 1, 32'h200, 1, 1, 0, 1);
        step(0, 0, 32'h0,   3'b000, 0, 0, 32'h0,   1, 1, 0, 1);
        step(0, 0, 32'h0,   3'b000, 1, 0, 32'h0,   0, 0, 0, 1);
        step(0, 0, 32'h0,   3'b000, 0, 0, 32'h0,   0, 0, 0, 0);

        // Watchdog: source 2 held, clear beats a simultaneous set
        step(0, 0, 32'h0, 3'b100, 0, 0, 32'h0, 0, 1, 2, 0);
        step(0, 0, 32'h0, 3'b100, 0, 0, 32'h0, 0, 1, 2, 0);
        step(0, 0, 32'h0, 3'b110, 0, 0, 32'h0, 0, 1, 1, 0);
        step(0, 0, 32'h0, 3'b100, 0, 0, 32'h0, 0, 1, 2, 0);
        step(0, 0, 32'h0, 3'b100, 0, 0, 32'h0, 0, 1, 2, 1);
        step(0, 0, 32'h0, 3'b100, 1, 0, 32'h0, 0, 1, 2, 1);
        step(0, 0, 32'h0, 3'b100, 0, 0, 32'h0, 0, 1, 2, 0);
        step(0, 0, 32'h0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 1);
        step(0, 0, 32'h0, 3'b000, 1, 0, 32'h0, 0, 0, 0, 1);
        step(0, 0, 32'h0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 0);

        // New jump in first flush cycle restarts the flush
        step(0, 1, 32'h40, 3'b000, 0, 1, 32'h40, 1, 1, 0, 0);
        step(0, 1, 32'h80, 3'b000, 0, 1, 32'h80, 1, 1, 0, 0);
        step(0, 0, 32'h5,  3'b000, 0, 0, 32'h5,  1, 1, 0, 0);
        step(0, 0, 32'h6,  3'b000, 0, 0, 32'h6,  0, 0, 0, 0);

        // Jump during flush under hold pends; reset in JPEND discards it
        step(0, 1, 32'h60, 3'b000, 0, 1, 32'h60, 1, 1, 0, 0);
        step(0, 1, 32'h70, 3'b001, 0, 0, 32'h70, 1, 1, 0, 0);
        step(0, 0, 32'h9,  3'b001, 0, 0, 32'h9,  0, 1, 0, 0);
        step(1, 0, 32'h9,  3'b000, 0, 0, 32'h0,  0, 0, 0, 0);
        step(1, 0, 32'h9,  3'b000, 0, 0, 32'h0,  0, 0, 0, 0);
        step(0, 0, 32'hC,  3'b000, 0, 0, 32'hC,  0, 0, 0, 0);
        step(0, 0, 32'hD,  3'b000, 0, 0, 32'hD,  0, 0, 0, 0);

        // 4-bit stall counter wraps on the 16th stall cycle
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 32'h0, 3'b001, 0, 0, 32'h0, 0, 1, 0, (i >= 4));
        end
        step(0, 0, 32'h0, 3'b000, 1, 0, 32'h0, 0, 0, 0, 1);
        step(0, 0, 32'h0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end
endmodule
